// File: rtl/spi_flash_reader_if.sv
// Request/response bus between a requester and the SPI flash read master.
interface spi_flash_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        req_quad;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;

    modport master (
        output req_valid, req_addr, req_quad,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_addr, req_quad,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI flash word reader (0x03 single / 0xEB quad), wakes the flash with 0xAB after reset.
// Response 2*DIV*C+1-DIV cycles after acceptance (C = 64 or 32 SCK); one request at a time, no response backpressure.
module spi_flash_reader #(
    parameter int DIV     = 1,
    parameter int CSB_GAP = 4
) (
    input  logic              clk,
    input  logic              resetn,
    spi_flash_reader_if.slave bus,
    output logic              flash_csb,
    output logic              flash_clk,
    output logic [3:0]        flash_io_oe,
    output logic [3:0]        flash_io_do,
    input  logic [3:0]        flash_io_di
);
    localparam int HW = $clog2(DIV) + 1;
    localparam int GW = $clog2(CSB_GAP) + 1;
    localparam logic [HW-1:0] HLAST = HW'(DIV - 1);
    localparam logic [GW-1:0] GLAST = GW'(CSB_GAP - 1);

    typedef enum logic [3:0] {WAKE, WAKE_GAP, IDLE, CMD, ADDR, MODE, DUMMY, DATA, GAP} state_t;

    state_t        state, nstate;
    logic          quad;
    logic [23:0]   addr_q;
    logic [31:0]   sr, nsr, shin;
    logic [5:0]    cnt, len;
    logic [HW-1:0] hcnt;
    logic [GW-1:0] gcnt;
    logic          last, wide;
    logic [3:0]    noe, ndo;
    logic          req_ready_r, rsp_valid_r, busy_r;
    logic [31:0]   rsp_data_r;

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.busy      = busy_r;

    // What the next SCK cycle looks like once the current one ends on a falling edge.
    always_comb begin
        len  = 6'd8;
        wide = 1'b0;
        case (state)
            ADDR:    begin len = quad ? 6'd6 : 6'd24; wide = quad; end
            MODE:    begin len = 6'd2; wide = 1'b1; end
            DATA:    len = quad ? 6'd8 : 6'd32;
            default: len = 6'd8;
        endcase
        last   = (cnt == len - 6'd1);
        nstate = state;
        if (last) begin
            case (state)
                WAKE:    nstate = WAKE_GAP;
                CMD:     nstate = ADDR;
                ADDR:    nstate = quad ? MODE : DATA;
                MODE:    nstate = DUMMY;
                DUMMY:   nstate = DATA;
                DATA:    nstate = GAP;
                default: nstate = state;
            endcase
        end
        nsr = wide ? {sr[27:0], 4'h0} : {sr[30:0], 1'b0};
        if (state == CMD && last)
            nsr = {addr_q, 8'h00};
        noe = 4'b0000;
        ndo = 4'b0000;
        case (nstate)
            WAKE, CMD: begin noe = 4'b0001; ndo = {3'b000, nsr[31]}; end
            ADDR, MODE: begin
                if (quad) begin noe = 4'b1111; ndo = nsr[31:28]; end
                else begin noe = 4'b0001; ndo = {3'b000, nsr[31]}; end
            end
            default: begin noe = 4'b0000; ndo = 4'b0000; end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= WAKE;
            flash_csb   <= 1'b1;
            flash_clk   <= 1'b0;
            flash_io_oe <= 4'b0000;
            flash_io_do <= 4'b0000;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'h0;
            busy_r      <= 1'b1;
            sr          <= 32'hAB00_0000;
            quad        <= 1'b0;
            addr_q      <= 24'h0;
            shin        <= 32'h0;
            cnt         <= 6'd0;
            hcnt        <= '0;
            gcnt        <= '0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state)
                WAKE_GAP, GAP: begin
                    if (gcnt == '0) begin
                        state       <= IDLE;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        gcnt <= gcnt - GW'(1);
                    end
                end
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q      <= bus.req_addr;
                        quad        <= bus.req_quad;
                        sr          <= {bus.req_quad ? 8'hEB : 8'h03, bus.req_addr};
                        flash_csb   <= 1'b0;
                        flash_io_oe <= 4'b0001;
                        flash_io_do <= {3'b000, bus.req_quad};
                        cnt         <= 6'd0;
                        hcnt        <= '0;
                        state       <= CMD;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                end
                default: begin
                    // csb still high here only at the very start of the wake command.
                    if (flash_csb) begin
                        flash_csb   <= 1'b0;
                        flash_io_oe <= 4'b0001;
                        flash_io_do <= {3'b000, sr[31]};
                        cnt         <= 6'd0;
                        hcnt        <= '0;
                    end else if (flash_clk && state == DATA && last) begin
                        flash_csb   <= 1'b1;
                        flash_clk   <= 1'b0;
                        flash_io_oe <= 4'b0000;
                        flash_io_do <= 4'b0000;
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= {shin[7:0], shin[15:8], shin[23:16], shin[31:24]};
                        state       <= GAP;
                        gcnt        <= GLAST;
                    end else if (hcnt != HLAST) begin
                        hcnt <= hcnt + HW'(1);
                    end else begin
                        hcnt <= '0;
                        if (!flash_clk) begin
                            flash_clk <= 1'b1;
                            if (state == DATA)
                                shin <= quad ? {shin[27:0], flash_io_di} : {shin[30:0], flash_io_di[1]};
                        end else begin
                            flash_clk   <= 1'b0;
                            sr          <= nsr;
                            state       <= nstate;
                            cnt         <= last ? 6'd0 : cnt + 6'd1;
                            flash_io_oe <= noe;
                            flash_io_do <= ndo;
                            if (state == WAKE && last) begin
                                flash_csb <= 1'b1;
                                gcnt      <= GLAST;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI flash plus randomized reads against a byte-array model.
module tb_spi_flash_reader;
    localparam int DIV     = 1;
    localparam int CSB_GAP = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    spi_flash_reader_if bus();
    logic       flash_csb, flash_clk;
    logic [3:0] flash_io_oe, flash_io_do;
    logic [3:0] fdi = 4'h0;

    spi_flash_reader #(.DIV(DIV), .CSB_GAP(CSB_GAP)) dut (
        .clk(clk), .resetn(resetn), .bus(bus),
        .flash_csb(flash_csb), .flash_clk(flash_clk),
        .flash_io_oe(flash_io_oe), .flash_io_do(flash_io_do), .flash_io_di(fdi)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- flash model ----------------
    logic [7:0] mem [int];
    int         edges = 0;
    bit         in_tr = 0;
    bit         xip_cmd = 0;
    logic [3:0] ed_oe [64];
    logic [3:0] ed_do [64];
    int         tr_edges [$];
    logic [7:0] tr_cmd [$];

    function automatic logic [7:0] mem_rd(int a);
        int m = a & 32'h00FF_FFFF;
        if (mem.exists(m)) return mem[m];
        return 8'(m * 13 + 7);
    endfunction

    function automatic logic [31:0] exp_word(int a);
        return {mem_rd(a + 3), mem_rd(a + 2), mem_rd(a + 1), mem_rd(a)};
    endfunction

    function automatic logic [7:0] seen_cmd();
        logic [7:0] c = 8'h00;
        for (int i = 0; i < 8; i++) c = {c[6:0], ed_do[i][0]};
        return c;
    endfunction

    function automatic int seen_addr();
        int a = 0;
        if (seen_cmd() == 8'hEB) for (int i = 8; i < 14; i++) a = (a << 4) | int'(ed_do[i]);
        else for (int i = 8; i < 32; i++) a = (a << 1) | int'(ed_do[i][0]);
        return a;
    endfunction

    function automatic logic [3:0] drive(int k);
        logic [7:0] b;
        int n;
        if (k < 8) return 4'h0;
        if (seen_cmd() == 8'h03 && k >= 32 && k < 64) begin
            n = k - 32;
            b = mem_rd(seen_addr() + n / 8);
            return {2'b00, b[7 - (n % 8)], 1'b0};
        end
        if (seen_cmd() == 8'hEB && k >= 24 && k < 32) begin
            n = k - 24;
            b = mem_rd(seen_addr() + n / 2);
            return (n % 2 == 0) ? b[7:4] : b[3:0];
        end
        return 4'h0;
    endfunction

    always @(negedge flash_csb) begin
        in_tr = 1;
        edges = 0;
        fdi   = 4'h0;
    end
    always @(posedge flash_csb) begin
        if (in_tr) begin
            tr_edges.push_back(edges);
            tr_cmd.push_back(edges >= 8 ? seen_cmd() : 8'h00);
        end
        in_tr = 0;
    end
    always @(posedge flash_clk) begin
        if (in_tr && flash_csb === 1'b0) begin
            if (edges < 64) begin
                ed_oe[edges] = flash_io_oe;
                ed_do[edges] = flash_io_do;
            end
            edges++;
            if (edges == 16 && seen_cmd() == 8'hEB && {ed_do[14], ed_do[15]} == 8'hA5) xip_cmd = 1;
        end
    end
    always @(negedge flash_clk) begin
        if (in_tr && flash_csb === 1'b0) fdi = drive(edges);
    end

    // ---------------- response monitor ----------------
    int          rsp_cyc_q [$];
    logic [31:0] rsp_dat_q [$];
    bit          rsp_side_q [$];
    int          double_pulse = 0;
    bit          prev_rsp = 0;
    bit          prev_csb = 1;
    int          csb_rise = 0;

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            rsp_cyc_q.push_back(cyc + 1);
            rsp_dat_q.push_back(bus.rsp_data);
            rsp_side_q.push_back(flash_csb === 1'b1 && flash_clk === 1'b0 && flash_io_oe === 4'b0000);
            if (prev_rsp) double_pulse++;
        end
        prev_rsp = (bus.rsp_valid === 1'b1);
        if (flash_csb === 1'b1 && !prev_csb) csb_rise = cyc + 1;
        prev_csb = (flash_csb === 1'b1);
    end

    // ---------------- drivers (no checking) ----------------
    function automatic int exp_lat(logic q);
        int c = q ? 32 : 64;
        return 2 + 2 * DIV * (c - 1) + DIV;
    endfunction

    task automatic fill4(int a);
        for (int i = 0; i < 4; i++) mem[(a + i) & 32'h00FF_FFFF] = 8'($urandom);
    endtask

    task automatic issue(input logic [23:0] a, input logic q, input bit hold, output int t);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_quad  = q;
        while (bus.req_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        t = (bus.req_ready === 1'b1) ? cyc + 1 : -100000;
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int r, output logic [31:0] d, output bit side);
        int n = 0;
        while (rsp_cyc_q.size() == 0 && n < 3000) begin @(negedge clk); n++; end
        if (rsp_cyc_q.size() == 0) begin
            r = -1; d = 32'hxxxx_xxxx; side = 0;
        end else begin
            r = rsp_cyc_q.pop_front(); d = rsp_dat_q.pop_front(); side = rsp_side_q.pop_front();
        end
    endtask

    task automatic wait_ready(output int rdy);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        rdy = (bus.req_ready === 1'b1) ? cyc + 1 : -100000;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 3;
        if ({flash_csb, flash_clk, flash_io_oe, flash_io_do} !== 10'b1_0_0000_0000) begin
            errors++; $display("FAIL reset_pins got %b want 1000000000", {flash_csb, flash_clk, flash_io_oe, flash_io_do});
        end
        if ({bus.req_ready, bus.rsp_valid, bus.busy} !== 3'b001) begin
            errors++; $display("FAIL reset_bus got %b want 001", {bus.req_ready, bus.rsp_valid, bus.busy});
        end
        if (bus.rsp_data !== 32'h0) begin
            errors++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data);
        end
    endtask

    task automatic test_wake();
        int  rdy;
        bit  oe_ok = 1;
        @(negedge clk);
        resetn = 1'b1;
        wait_ready(rdy);
        for (int i = 0; i < 8; i++) if (ed_oe[i] !== 4'b0001) oe_ok = 0;
        checks += 5;
        if (tr_cmd.size() != 1 || tr_cmd[0] !== 8'hAB) begin
            errors++; $display("FAIL wake_cmd got n=%0d cmd=%h want n=1 cmd=ab", tr_cmd.size(), tr_cmd.size() ? tr_cmd[0] : 8'h00);
        end
        if (tr_edges.size() != 1 || tr_edges[0] != 8) begin
            errors++; $display("FAIL wake_sck got %0d want 8", tr_edges.size() ? tr_edges[0] : -1);
        end
        if (!oe_ok) begin errors++; $display("FAIL wake_oe got non-0001 want 0001"); end
        if (rdy - csb_rise < CSB_GAP) begin
            errors++; $display("FAIL wake_gap got %0d want >=%0d", rdy - csb_rise, CSB_GAP);
        end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL wake_idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_single();
        int t, r; logic [31:0] d; bit side; bit oe_ok = 1;
        mem[32'h10] = 8'h11; mem[32'h11] = 8'h22; mem[32'h12] = 8'h33; mem[32'h13] = 8'h44;
        issue(24'h000010, 1'b0, 1'b0, t);
        wait_rsp(r, d, side);
        for (int i = 0; i < 64; i++) if (ed_oe[i] !== (i < 32 ? 4'b0001 : 4'b0000)) oe_ok = 0;
        checks += 6;
        if (d !== 32'h4433_2211) begin errors++; $display("FAIL single_data got %h want 44332211", d); end
        if (r != t + 129) begin errors++; $display("FAIL single_latency got %0d want %0d", r - t, 129); end
        if (!side) begin errors++; $display("FAIL single_end_pins got csb/clk/oe not idle want idle"); end
        if (tr_cmd[$] !== 8'h03 || seen_addr() != 32'h10) begin
            errors++; $display("FAIL single_cmd got %h/%h want 03/000010", tr_cmd[$], seen_addr());
        end
        if (!oe_ok || tr_edges[$] != 64) begin
            errors++; $display("FAIL single_oe got ok=%0d sck=%0d want ok=1 sck=64", oe_ok, tr_edges[$]);
        end
        repeat (10) @(negedge clk);
        if (rsp_cyc_q.size() != 0 || double_pulse != 0 || bus.rsp_data !== 32'h4433_2211) begin
            errors++; $display("FAIL single_pulse got extra=%0d dbl=%0d hold=%h want 0 0 44332211",
                               rsp_cyc_q.size(), double_pulse, bus.rsp_data);
        end
    endtask

    task automatic test_quad();
        int t, r; logic [31:0] d; bit side; bit dummy_ok = 1; bit addr_ok = 1;
        issue(24'h000010, 1'b1, 1'b0, t);
        wait_rsp(r, d, side);
        for (int i = 16; i < 24; i++) if (ed_oe[i] !== 4'b0000) dummy_ok = 0;
        for (int i = 8; i < 16; i++) if (ed_oe[i] !== 4'b1111) addr_ok = 0;
        checks += 6;
        if (d !== 32'h4433_2211) begin errors++; $display("FAIL quad_data got %h want 44332211", d); end
        if (r != t + 65) begin errors++; $display("FAIL quad_latency got %0d want 65", r - t); end
        if (ed_do[14] !== 4'h0 || ed_do[15] !== 4'h0 || xip_cmd) begin
            errors++; $display("FAIL quad_mode got %h%h xip=%0d want 00 xip=0", ed_do[14], ed_do[15], xip_cmd);
        end
        if (!dummy_ok) begin errors++; $display("FAIL quad_dummy_oe got driven want 0000"); end
        if (!addr_ok || tr_cmd[$] !== 8'hEB || seen_addr() != 32'h10) begin
            errors++; $display("FAIL quad_addr got ok=%0d cmd=%h addr=%h want 1/eb/000010", addr_ok, tr_cmd[$], seen_addr());
        end
        if (!side || tr_edges[$] != 32) begin
            errors++; $display("FAIL quad_end got side=%0d sck=%0d want 1 32", side, tr_edges[$]);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, r1, r2; logic [31:0] d1, d2; bit s1, s2;
        fill4(0); fill4(4);
        issue(24'h000000, 1'b1, 1'b1, t1);
        issue(24'h000004, 1'b1, 1'b0, t2);
        wait_rsp(r1, d1, s1);
        wait_rsp(r2, d2, s2);
        checks += 4;
        if (t2 != r1 + CSB_GAP) begin errors++; $display("FAIL b2b_accept got %0d want %0d", t2 - r1, CSB_GAP); end
        if (d1 !== exp_word(0)) begin errors++; $display("FAIL b2b_data0 got %h want %h", d1, exp_word(0)); end
        if (d2 !== exp_word(4)) begin errors++; $display("FAIL b2b_data1 got %h want %h", d2, exp_word(4)); end
        if (r2 != t2 + 65) begin errors++; $display("FAIL b2b_latency got %0d want 65", r2 - t2); end
    endtask

    task automatic test_wrap();
        int t, r; logic [31:0] d; bit side;
        fill4(32'hFFFFFE);
        issue(24'hFFFFFE, 1'b1, 1'b0, t);
        wait_rsp(r, d, side);
        checks += 2;
        if (d !== {mem[1], mem[0], mem[32'hFFFFFF], mem[32'hFFFFFE]}) begin
            errors++; $display("FAIL wrap_data got %h want %h", d, {mem[1], mem[0], mem[32'hFFFFFF], mem[32'hFFFFFE]});
        end
        if (seen_addr() != 32'hFFFFFE) begin errors++; $display("FAIL wrap_addr got %h want fffffe", seen_addr()); end
    endtask

    task automatic test_random();
        int t, r, a; logic q; logic [31:0] d; bit side;
        for (int it = 0; it < 8; it++) begin
            a = int'($urandom & 32'h00FF_FFFF);
            q = 1'($urandom_range(0, 1));
            fill4(a);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            issue(24'(a), q, 1'b0, t);
            wait_rsp(r, d, side);
            checks += 2;
            if (d !== exp_word(a)) begin errors++; $display("FAIL rand_data a=%h q=%0d got %h want %h", a, q, d, exp_word(a)); end
            if (r != t + exp_lat(q)) begin errors++; $display("FAIL rand_latency q=%0d got %0d want %0d", q, r - t, exp_lat(q)); end
        end
    endtask

    task automatic test_reset_mid();
        int t, r, n, ntr, rdy; logic [31:0] d; bit side;
        fill4(32'h00ABC0);
        issue(24'h00ABC0, 1'b0, 1'b0, t);
        n = 0;
        while (edges < 16 && n < 400) begin @(negedge clk); n++; end
        resetn = 1'b0;
        #1;
        checks += 1;
        if (flash_csb !== 1'b1 || flash_io_oe !== 4'b0000 || bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_pins got csb=%b oe=%b busy=%b rdy=%b want 1 0000 1 0",
                               flash_csb, flash_io_oe, bus.busy, bus.req_ready);
        end
        ntr = tr_edges.size();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wait_ready(rdy);
        checks += 3;
        if (rsp_cyc_q.size() != 0) begin errors++; $display("FAIL midrst_rsp got %0d want 0", rsp_cyc_q.size()); end
        if (ntr < 1 || tr_edges[ntr - 1] < 9 || tr_edges[ntr - 1] > 32) begin
            errors++; $display("FAIL midrst_abort got sck=%0d want 9..32", ntr ? tr_edges[ntr - 1] : -1);
        end
        if (tr_cmd.size() != ntr + 1 || tr_cmd[$] !== 8'hAB || tr_edges[$] != 8) begin
            errors++; $display("FAIL midrst_wake got n=%0d cmd=%h sck=%0d want n=%0d ab 8", tr_cmd.size(), tr_cmd[$], tr_edges[$], ntr + 1);
        end
        issue(24'h00ABC0, 1'b1, 1'b0, t);
        wait_rsp(r, d, side);
        checks += 1;
        if (d !== exp_word(32'h00ABC0) || r != t + 65) begin
            errors++; $display("FAIL midrst_read got %h lat %0d want %h lat 65", d, r - t, exp_word(32'h00ABC0));
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = 24'h0;
        bus.req_quad  = 1'b0;
        resetn        = 1'b0;
        test_reset();
        test_wake();
        test_single();
        test_quad();
        test_back_to_back();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
